// File: rtl/muldiv_pkg.sv
// Shared types and constants for the muldiv_ex unit.
// Division ops count as supported only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_t;

    // Returns 1 when the {funct7, funct3} code selects an op this unit executes
    function automatic logic is_supported(input logic [9:0] funct);
        logic ok;
        ok = 1'b0;
        if (funct[9:3] == FUNCT7_MULDIV) begin
            case (funct[2:0])
                F3_MUL:                           ok = 1'b1;
                F3_DIV, F3_DIVU, F3_REM, F3_REMU: ok = DIV_EN;
                default:                          ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step; only built when MULDIV_DIV_EN
// is defined, so the default build carries no divider logic.
`ifdef MULDIV_DIV_EN
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem_in < divisor keeps the trial difference within XLEN+1 bits
    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[XLEN];
    assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule
`endif

// File: rtl/muldiv_ex.sv
// muldiv_ex: iterative RV32M execute unit, one shift-add / shift-subtract step per cycle.
// DIV/DIVU/REM/REMU and the DIV state exist only when MULDIV_DIV_EN is defined.
import muldiv_pkg::*;

module muldiv_ex #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            valid_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] RS1data_i,
    input  logic [XLEN-1:0] RS2data_i,
    input  logic            mem_stall_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam logic [4:0] LAST_STEP = 5'd31;

    state_t          state;
    logic [4:0]      count;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] result_q;
    logic            skip_idle;
    logic            accept;
    logic [XLEN-1:0] mul_sum;

    // skip_idle blocks re-accepting the instruction still parked in ID_EX after DONE
    assign accept   = rst_i && (state == ST_IDLE) && !skip_idle && valid_i && start_i
                      && is_supported(funct_i);
    assign mul_sum  = acc + (op_b[0] ? op_a : '0);
    assign done_o   = (state == ST_DONE);
    assign result_o = result_q;

`ifdef MULDIV_DIV_EN
    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic            neg_q;
    logic            neg_r;
    logic            sel_rem;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] fix_quo;
    logic [XLEN-1:0] fix_rem;
    logic            step_q;

    assign signed_op = ~funct_i[0];
    assign a_neg     = signed_op & RS1data_i[XLEN-1];
    assign b_neg     = signed_op & RS2data_i[XLEN-1];
    assign abs_a     = a_neg ? -RS1data_i : RS1data_i;
    assign abs_b     = b_neg ? -RS2data_i : RS2data_i;

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in       (acc),
        .dividend_bit (op_a[XLEN-1]),
        .divisor      (op_b),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    assign step_quo = {op_a[XLEN-2:0], step_q};
    assign fix_quo  = neg_q ? -step_quo : step_quo;
    assign fix_rem  = neg_r ? -step_rem : step_rem;
    assign busy_o   = accept || (state == ST_MUL) || (state == ST_DIV);
`else
    assign busy_o   = accept || (state == ST_MUL);
`endif

    // Sequencer and datapath: op_a/op_b/acc are multiplicand/multiplier/product
    // for MUL and dividend-quotient/divisor/remainder for division.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            count     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            result_q  <= '0;
            skip_idle <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            sel_rem   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    skip_idle <= 1'b0;
                    if (accept) begin
                        count <= '0;
                        acc   <= '0;
`ifdef MULDIV_DIV_EN
                        if (funct_i[2]) begin
                            op_a    <= abs_a;
                            op_b    <= abs_b;
                            // a zero divisor must leave the all-ones quotient intact
                            neg_q   <= (a_neg ^ b_neg) && (RS2data_i != '0);
                            neg_r   <= a_neg;
                            sel_rem <= funct_i[1];
                            state   <= ST_DIV;
                        end else
`endif
                        begin
                            op_a  <= RS1data_i;
                            op_b  <= RS2data_i;
                            state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    acc   <= mul_sum;
                    op_a  <= op_a << 1;
                    op_b  <= op_b >> 1;
                    count <= count + 5'd1;
                    if (count == LAST_STEP) begin
                        result_q <= mul_sum;
                        state    <= ST_DONE;
                    end
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    acc   <= step_rem;
                    op_a  <= step_quo;
                    count <= count + 5'd1;
                    if (count == LAST_STEP) begin
                        result_q <= sel_rem ? fix_rem : fix_quo;
                        state    <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (!mem_stall_i) begin
                        state     <= ST_IDLE;
                        skip_idle <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ex.sv
// Self-checking bench for muldiv_ex: directed corner cases plus random ops
// compared against a plain-arithmetic RV32M reference model.
module tb_muldiv_ex;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        valid_i;
    logic [9:0]  funct_i;
    logic [31:0] RS1data_i;
    logic [31:0] RS2data_i;
    logic        mem_stall_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_result;

    always #5 clk_i = ~clk_i;

    muldiv_ex #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .valid_i     (valid_i),
        .funct_i     (funct_i),
        .RS1data_i   (RS1data_i),
        .RS2data_i   (RS2data_i),
        .mem_stall_i (mem_stall_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic op_supported(input logic [2:0] f3);
        if (f3 == 3'b000) return 1'b1;
`ifdef MULDIV_DIV_EN
        if (f3[2]) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // RV32M semantics from plain arithmetic, including the divide-by-zero and overflow rules
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : sa / sb);
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : (ovf ? 32'd0 : sa % sb);
            3'b111: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input int stall, input bit drop_start);
        int          cycles;
        logic [31:0] exp;
        exp = ref_result(f3, a, b);
        @(negedge clk_i);
        valid_i   = 1'b1;
        start_i   = 1'b1;
        funct_i   = {7'b0000001, f3};
        RS1data_i = a;
        RS2data_i = b;
        #1;
        if (!op_supported(f3)) begin
            checkOutput("unsup_busy", {31'd0, busy_o}, 32'd0);
            @(negedge clk_i);
            checkOutput("unsup_done", {31'd0, done_o}, 32'd0);
            checkOutput("unsup_result", result_o, model_result);
            valid_i = 1'b0;
            return;
        end
        checkOutput("accept_busy", {31'd0, busy_o}, 32'd1);
        cycles = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (i == 0) begin
                RS1data_i = $urandom;
                RS2data_i = $urandom;
            end
            if (drop_start && i == 5) start_i = 1'b0;
            if (!busy_o) break;
            cycles++;
        end
        start_i = 1'b1;
        checkOutput("busy_cycles", cycles, 32'd33);
        checkOutput("done", {31'd0, done_o}, 32'd1);
        checkOutput("result", result_o, exp);
        model_result = exp;
        if (stall > 0) mem_stall_i = 1'b1;
        for (int k = 1; k <= stall; k++) begin
            @(negedge clk_i);
            if (k == stall) mem_stall_i = 1'b0;
            checkOutput("stall_done", {31'd0, done_o}, 32'd1);
            checkOutput("stall_busy", {31'd0, busy_o}, 32'd0);
            checkOutput("stall_result", result_o, exp);
        end
        @(negedge clk_i);
        checkOutput("reexec_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("idle_done", {31'd0, done_o}, 32'd0);
        checkOutput("hold_result", result_o, exp);
        valid_i = 1'b0;
    endtask

    task automatic resetMidMul(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        valid_i   = 1'b1;
        start_i   = 1'b1;
        funct_i   = 10'b0000001_000;
        RS1data_i = a;
        RS2data_i = b;
        repeat (11) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("midrst_done", {31'd0, done_o}, 32'd0);
        checkOutput("midrst_result", result_o, 32'd0);
        model_result = 32'd0;
        @(negedge clk_i);
        rst_i   = 1'b1;
        valid_i = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_i        = 1'b0;
        start_i      = 1'b0;
        valid_i      = 1'b0;
        mem_stall_i  = 1'b0;
        funct_i      = '0;
        RS1data_i    = '0;
        RS2data_i    = '0;
        model_result = '0;
        repeat (2) @(negedge clk_i);
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_done", {31'd0, done_o}, 32'd0);
        checkOutput("rst_result", result_o, 32'd0);
        rst_i = 1'b1;

        // start_i low must hold the unit idle
        @(negedge clk_i);
        valid_i = 1'b1;
        funct_i = 10'b0000001_000;
        #1;
        checkOutput("nostart_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        checkOutput("nostart_done", {31'd0, done_o}, 32'd0);
        valid_i = 1'b0;

        applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
        applyStimulus(3'b100, 32'hFFFF_FFEC, 32'd6, 0, 1'b1);
        applyStimulus(3'b110, 32'hFFFF_FFEC, 32'd6, 0, 1'b0);
        applyStimulus(3'b101, 32'h1234_5678, 32'd0, 0, 1'b0);
        applyStimulus(3'b111, 32'h1234_5678, 32'd0, 0, 1'b0);
        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        applyStimulus(3'b100, 32'h8000_0005, 32'd0, 0, 1'b0);
        applyStimulus(3'b110, 32'h8000_0005, 32'd0, 0, 1'b0);
        applyStimulus(3'b001, 32'h0000_1111, 32'd3, 0, 1'b0);
        applyStimulus(3'b010, 32'h0000_2222, 32'd5, 0, 1'b0);
        applyStimulus(3'b011, 32'h0000_3333, 32'd9, 0, 1'b0);
        applyStimulus(3'b000, 32'hDEAD_BEEF, 32'h0000_0101, 4, 1'b0);

        resetMidMul(32'h0001_2345, 32'h0000_0777);
        applyStimulus(3'b000, 32'd3, 32'd5, 0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            f3 = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            applyStimulus(f3, ra, rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
